cmp_frame_sequencer: RTL

//  Sequences one test frame through the compressor harness (shift_register + compressor). It streams
//  MAX_HEIGHT rows of column bits into the per-column shift registers using a shift enable, then waits
//  out the compressor latency. It captures dst[NOUT-1:0] and compares it against a sum it accumulates

---
 rtl/cmp_frame_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cmp_frame_sequencer.sv
// Frame sequencer for the compressor harness: streams MAX_HEIGHT rows into the column shift
// registers, waits out the compressor latency, then compares dst against a locally accumulated sum.
module cmp_frame_sequencer #(
  parameter int NCOL       = 47,
  parameter int MAX_HEIGHT = 24,
  parameter int NOUT       = 49,
  parameter int LATENCY    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NCOL-1:0] in_bits,
  output logic            sh_en,
  output logic [NCOL-1:0] sh_bits,
  input  logic [NOUT-1:0] dst,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NOUT-1:0] res_data,
  output logic            res_mismatch,
  output logic            busy
);

  localparam int ROW_W    = $clog2(MAX_HEIGHT + 1);
  localparam int SUM_W    = NCOL + ROW_W;
  localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [SUM_W-1:0]     exp_sum_q, exp_sum_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [NOUT-1:0]      res_data_q, res_data_d;
  logic                 res_mismatch_q, res_mismatch_d;

  logic accept;
  logic last_row;
  logic lat_done;

  // Column i only retains the bits of rows r >= MAX_HEIGHT - h(i), h(i) = min(i+1, NCOL-i).
  function automatic logic [NCOL-1:0] keep_mask(input logic [ROW_W-1:0] row);
    int h;
    keep_mask = '0;
    for (int i = 0; i < NCOL; i++) begin
      h = (i + 1 < NCOL - i) ? i + 1 : NCOL - i;
      keep_mask[i] = (int'(row) >= MAX_HEIGHT - h);
    end
  endfunction

  assign accept   = in_valid & in_ready;
  assign last_row = (row_cnt_q == ROW_W'(MAX_HEIGHT - 1));
  assign lat_done = (lat_cnt_q == LAT_W'(LAT_LAST));

  // NOTE: the whole control path resets asynchronously so a mid-frame reset abandons the frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      row_cnt_q      <= '0;
      exp_sum_q      <= '0;
      lat_cnt_q      <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_mismatch_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values of its neighbours.
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      exp_sum_q      <= exp_sum_d;
      lat_cnt_q      <= lat_cnt_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_mismatch_q <= res_mismatch_d;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (last_row) state_d = (LATENCY > 0) ? S_FLUSH : S_CAPTURE;
          else          state_d = S_LOAD;
        end
      end
      S_FLUSH:   if (lat_done) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    if (res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_cnt_d      = row_cnt_q;
    exp_sum_d      = exp_sum_q;
    lat_cnt_d      = lat_cnt_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_mismatch_d = res_mismatch_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
          exp_sum_d = exp_sum_q + SUM_W'(in_bits & keep_mask(row_cnt_q));
        end
      end
      S_FLUSH: lat_cnt_d = lat_done ? '0 : lat_cnt_q + LAT_W'(1);
      S_CAPTURE: begin
        res_data_d     = dst;
        res_mismatch_d = (dst != exp_sum_q[NOUT-1:0]);
        res_valid_d    = 1'b1;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          exp_sum_d   = '0;
          row_cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // in_ready is qualified by rst_n so an asserted reset silences the harness interface immediately.
  always_comb begin
    in_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_LOAD));
    sh_en    = in_valid && in_ready;
    sh_bits  = sh_en ? in_bits : '0;
    busy     = (state_q != S_IDLE);
  end

  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_mismatch = res_mismatch_q;

endmodule
